nvdla_dbb_rd_arb: RTL

NVDLA_DBB_RD_ARB -- requirements
Module: nvdla_dbb_rd_arb

---
 rtl/nvdla_dbb_rd_arb_if.sv | 40 ++++
 rtl/nvdla_dbb_rd_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nvdla_dbb_rd_arb_if.sv
// Request, AR-channel and R-monitor signals shared by the DBB read arbiter
// and its neighbours; the arbiter uses the master modport.
interface nvdla_dbb_rd_arb_if;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_addr;
  logic [15:0]  req_len;

  logic         nvdla_core2dbb_ar_arvalid;
  logic         nvdla_core2dbb_ar_arready;
  logic [7:0]   nvdla_core2dbb_ar_arid;
  logic [3:0]   nvdla_core2dbb_ar_arlen;
  logic [2:0]   nvdla_core2dbb_ar_arsize;
  logic [63:0]  nvdla_core2dbb_ar_araddr;

  logic         nvdla_core2dbb_r_rvalid;
  logic         nvdla_core2dbb_r_rready;
  logic [7:0]   nvdla_core2dbb_r_rid;
  logic         nvdla_core2dbb_r_rlast;

  modport master (
    input  req_valid, req_addr, req_len,
    output req_ready,
    output nvdla_core2dbb_ar_arvalid, nvdla_core2dbb_ar_arid, nvdla_core2dbb_ar_arlen,
    output nvdla_core2dbb_ar_arsize, nvdla_core2dbb_ar_araddr,
    input  nvdla_core2dbb_ar_arready,
    input  nvdla_core2dbb_r_rvalid, nvdla_core2dbb_r_rready, nvdla_core2dbb_r_rid,
    input  nvdla_core2dbb_r_rlast
  );

  modport slave (
    output req_valid, req_addr, req_len,
    input  req_ready,
    input  nvdla_core2dbb_ar_arvalid, nvdla_core2dbb_ar_arid, nvdla_core2dbb_ar_arlen,
    input  nvdla_core2dbb_ar_arsize, nvdla_core2dbb_ar_araddr,
    output nvdla_core2dbb_ar_arready,
    output nvdla_core2dbb_r_rvalid, nvdla_core2dbb_r_rready, nvdla_core2dbb_r_rid,
    output nvdla_core2dbb_r_rlast
  );
endinterface

// File: rtl/nvdla_dbb_rd_arb.sv
// Four-requester round-robin read arbiter onto one AXI AR channel, with per-requester
// outstanding-burst limits tracked from R rlast beats. Define NVDLA_DBB_ARB_PRIO0_EN for requester-0 priority.
module nvdla_dbb_rd_arb #(
  parameter int MAX_OS = 8
) (
  input  logic                     core_clk,
  input  logic                     rstn,
  nvdla_dbb_rd_arb_if.master       dbb,
  output logic                     arb_idle,
  output logic                     arb_err
);

  localparam logic [3:0] MAX_OS_C = 4'(MAX_OS);

  logic        arvalid_q, arvalid_d;
  logic [1:0]  arid_q, arid_d;
  logic [3:0]  arlen_q, arlen_d;
  logic [63:0] araddr_q, araddr_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        arb_err_q, arb_err_d;
  logic [3:0]  os_cnt_q [4];
  logic [3:0]  os_cnt_d [4];

  logic [63:0] req_addr_w [4];
  logic [3:0]  req_len_w [4];
  logic [3:0]  eligible, cnt_zero, inc, dec;
  logic        loadable, grant_vld, grant;
  logic [1:0]  grant_idx;
  logic        r_fire, r_bad;
  logic [1:0]  r_idx;

  assign loadable = !arvalid_q || dbb.nvdla_core2dbb_ar_arready;
  assign grant    = loadable && grant_vld;

  // A counted rlast must name a real requester that actually has a burst in flight.
  assign r_fire = dbb.nvdla_core2dbb_r_rvalid && dbb.nvdla_core2dbb_r_rready && dbb.nvdla_core2dbb_r_rlast;
  assign r_idx  = dbb.nvdla_core2dbb_r_rid[1:0];
  assign r_bad  = (dbb.nvdla_core2dbb_r_rid[7:2] != 6'd0) || (os_cnt_q[r_idx] == 4'd0);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign req_addr_w[gi] = dbb.req_addr[64*gi +: 64];
      assign req_len_w[gi]  = dbb.req_len[4*gi +: 4];
      assign eligible[gi]   = dbb.req_valid[gi] && (os_cnt_q[gi] < MAX_OS_C);
      assign cnt_zero[gi]   = (os_cnt_q[gi] == 4'd0);
      assign inc[gi]        = grant && (grant_idx == 2'(gi));
      assign dec[gi]        = r_fire && !r_bad && (r_idx == 2'(gi));
    end
  endgenerate

`ifdef NVDLA_DBB_ARB_PRIO0_EN
  // k-th requester in the 1..3 rotation starting at the pointer (pointer 0 acts as 1).
  function automatic logic [1:0] prio_slot(input logic [1:0] start, input int k);
    int s;
    s = (start == 2'd0) ? 0 : int'(start) - 1;
    return 2'((s + k) % 3 + 1);
  endfunction
`endif

  // Scan from the lowest priority up so the highest-priority eligible requester is written last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
`ifdef NVDLA_DBB_ARB_PRIO0_EN
    for (int k = 2; k >= 0; k--) begin
      if (eligible[prio_slot(rr_ptr_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = prio_slot(rr_ptr_q, k);
      end
    end
    if (eligible[0]) begin
      grant_vld = 1'b1;
      grant_idx = 2'd0;
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (eligible[rr_ptr_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_ptr_q + 2'(k);
      end
    end
`endif
  end

  always_comb begin
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    arlen_d   = arlen_q;
    araddr_d  = araddr_q;
    rr_ptr_d  = rr_ptr_q;
    arb_err_d = arb_err_q || (r_fire && r_bad);
    if (loadable) begin
      arvalid_d = grant_vld;
      if (grant_vld) begin
        arid_d   = grant_idx;
        arlen_d  = req_len_w[grant_idx];
        araddr_d = req_addr_w[grant_idx];
`ifdef NVDLA_DBB_ARB_PRIO0_EN
        if (grant_idx == 2'd3) begin
          rr_ptr_d = 2'd1;
        end else if (grant_idx != 2'd0) begin
          rr_ptr_d = grant_idx + 2'd1;
        end
`else
        rr_ptr_d = grant_idx + 2'd1;
`endif
      end
    end
  end

  // A grant and a retire in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      os_cnt_d[i] = os_cnt_q[i];
      if (inc[i] && !dec[i]) begin
        os_cnt_d[i] = os_cnt_q[i] + 4'd1;
      end else if (dec[i] && !inc[i]) begin
        os_cnt_d[i] = os_cnt_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge rstn) begin
    if (!rstn) begin
      arvalid_q <= 1'b0;
      arid_q    <= 2'd0;
      arlen_q   <= 4'd0;
      araddr_q  <= 64'd0;
      rr_ptr_q  <= 2'd0;
      arb_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        os_cnt_q[i] <= 4'd0;
      end
    end else begin
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      arlen_q   <= arlen_d;
      araddr_q  <= araddr_d;
      rr_ptr_q  <= rr_ptr_d;
      arb_err_q <= arb_err_d;
      for (int i = 0; i < 4; i++) begin
        os_cnt_q[i] <= os_cnt_d[i];
      end
    end
  end

  // rstn gates req_ready so no requester sees an accept while the arbiter is held in reset.
  assign dbb.req_ready = (grant && rstn) ? (4'b0001 << grant_idx) : 4'b0000;

  assign dbb.nvdla_core2dbb_ar_arvalid = arvalid_q;
  assign dbb.nvdla_core2dbb_ar_arid    = {6'b0, arid_q};
  assign dbb.nvdla_core2dbb_ar_arlen   = arlen_q;
  assign dbb.nvdla_core2dbb_ar_arsize  = 3'b101;
  assign dbb.nvdla_core2dbb_ar_araddr  = araddr_q;

  assign arb_idle = !arvalid_q && (&cnt_zero);
  assign arb_err  = arb_err_q;

endmodule
